// File: rtl/bench_misr_pkg.sv
// Shared types and helpers for the benchmark response compactor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bench_misr_pkg;

    // Widest signature the helper function can carry; SIG_W must not exceed it.
    localparam int MISR_MAX_W = 64;

    localparam logic [MISR_MAX_W-1:0] DEF_POLY = 64'h0000_0000_04C1_1DB7;
    localparam logic [MISR_MAX_W-1:0] DEF_SEED = 64'h0000_0000_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One MISR step on a w-bit signature held in the low bits of a wide word:
    // shift left, fold the bit shifted out back in through the polynomial,
    // then xor the (already zero-extended) data vector.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic                  msb;
        mask = (w >= MISR_MAX_W) ? '1
                                 : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
        msb  = |(sig & (MISR_MAX_W'(1) << (w - 1)));
        return ((sig << 1) ^ (msb ? poly : '0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register with seed load and single-step update.
// Latency: signature updates on the edge where step (or load_seed) is high.
// Backpressure: none; the caller decides when to step.
//  clk, rst_n  : clock, async active-low reset (clears the signature to 0)
//  load_seed   : load SEED (has priority over step)
//  step        : fold data into the signature
//  data        : input vector, zero-extended to SIG_W
//  sig         : current signature
//  sig_nxt     : signature that a step this cycle would produce
module misr_core
    import bench_misr_pkg::*;
#(
    parameter int                    SIG_W = 32,
    parameter int                    IN_W  = 26,
    parameter logic [MISR_MAX_W-1:0] POLY  = DEF_POLY,
    parameter logic [MISR_MAX_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_seed,
    input  logic             step,
    input  logic [IN_W-1:0]  data,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_nxt
);

    assign sig_nxt = SIG_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(data), POLY, SIG_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load_seed) begin
            sig <= SEED[SIG_W-1:0];
        end else if (step) begin
            sig <= sig_nxt;
        end
    end

endmodule

// File: rtl/bench_response_misr.sv
// Compacts a programmed number of benchmark output vectors into a MISR signature and compares to golden.
// Latency: done rises one cycle after the final accept (or after a zero-count start).
// Backpressure: resp_ready is high only in RUN, decoded from state alone; vectors offered elsewhere are ignored.
//  start/num_patterns/golden : launch a run (ignored while busy)
//  resp_valid/resp_ready/resp_data : vector handshake
//  busy/done/signature/match/count : run status and result
module bench_response_misr
    import bench_misr_pkg::*;
#(
    parameter int                    IN_W  = 26,
    parameter int                    SIG_W = 32,
    parameter logic [MISR_MAX_W-1:0] POLY  = DEF_POLY,
    parameter logic [MISR_MAX_W-1:0] SEED  = DEF_SEED,
    parameter int                    CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [SIG_W-1:0] golden,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [IN_W-1:0]  resp_data,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             match,
    output logic [CNT_W-1:0] count
);

    if (IN_W < 1 || IN_W > SIG_W || SIG_W > MISR_MAX_W) begin : g_bad_width
        $error("bench_response_misr: need 1 <= IN_W <= SIG_W <= %0d", MISR_MAX_W);
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_q;
    logic [SIG_W-1:0] golden_q;
    logic [SIG_W-1:0] sig_nxt;
    logic             start_ok;
    logic             accept;
    logic             last_accept;

    assign resp_ready  = (state == RUN);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign accept      = resp_valid & resp_ready;
    assign start_ok    = start & (state != RUN);
    // count < n_q throughout RUN, so count + 1 cannot overflow here.
    assign last_accept = accept && ((count + CNT_W'(1)) == n_q);

    misr_core #(
        .SIG_W (SIG_W),
        .IN_W  (IN_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (start_ok),
        .step      (accept),
        .data      (resp_data),
        .sig       (signature),
        .sig_nxt   (sig_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_patterns == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            n_q      <= '0;
            golden_q <= '0;
            match    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                count    <= '0;
                n_q      <= num_patterns;
                golden_q <= golden;
                // A zero-count run lands in DONE holding SEED, so judge it now.
                match    <= (num_patterns == '0) && (SEED[SIG_W-1:0] == golden);
            end else if (accept) begin
                count <= count + CNT_W'(1);
                if (last_accept) begin
                    match <= (sig_nxt == golden_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_bench_response_misr.sv
module tb_bench_response_misr;

    localparam logic [63:0] POLY_FULL = 64'h1_04C1_1DB7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_patterns = '0;
    logic [31:0] golden = '0;
    logic        resp_valid = 1'b0;
    logic [25:0] resp_data = '0;

    logic        a_ready, a_busy, a_done, a_match;
    logic [31:0] a_sig;
    logic [15:0] a_count;
    logic        b_ready, b_busy, b_done, b_match;
    logic [31:0] b_sig;
    logic [15:0] b_count;

    int checks = 0;
    int errors = 0;

    // Model state for the two instances (seed all-ones and seed zero).
    logic [31:0] ma, mb;

    always #5 clk = ~clk;

    bench_response_misr u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .num_patterns(num_patterns),
        .golden(golden), .resp_valid(resp_valid), .resp_ready(a_ready),
        .resp_data(resp_data), .busy(a_busy), .done(a_done),
        .signature(a_sig), .match(a_match), .count(a_count)
    );

    bench_response_misr #(.SEED(64'h0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .num_patterns(num_patterns),
        .golden(golden), .resp_valid(resp_valid), .resp_ready(b_ready),
        .resp_data(resp_data), .busy(b_busy), .done(b_done),
        .signature(b_sig), .match(b_match), .count(b_count)
    );

    // Signature = (signature * x + data) mod P(x) over GF(2), done with integer arithmetic.
    function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] d);
        logic [63:0] v;
        v = {32'b0, s} * 64'd2;
        if (v >= 64'h1_0000_0000) v = v ^ POLY_FULL;
        return v[31:0] ^ d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input logic [31:0] g);
        start = 1'b1;
        num_patterns = 16'(n);
        golden = g;
        tick();
        start = 1'b0;
        ma = 32'hFFFF_FFFF;
        mb = 32'h0;
    endtask

    task automatic feed(input logic [25:0] d);
        resp_valid = 1'b1;
        resp_data = d;
        tick();
        resp_valid = 1'b0;
        ma = mstep(ma, {6'b0, d});
        mb = mstep(mb, {6'b0, d});
    endtask

    task automatic test_reset();
        checks++;
        if ({a_ready, a_busy, a_done, a_match, a_sig, a_count} !== 52'h0) begin
            errors++;
            $display("FAIL reset_a: got rdy=%b busy=%b done=%b match=%b sig=%h cnt=%0d want all 0",
                     a_ready, a_busy, a_done, a_match, a_sig, a_count);
        end
        checks++;
        if ({b_ready, b_busy, b_done, b_match, b_sig, b_count} !== 52'h0) begin
            errors++;
            $display("FAIL reset_b: got sig=%h cnt=%0d busy=%b done=%b want all 0", b_sig, b_count, b_busy, b_done);
        end
    endtask

    task automatic test_single();
        do_start(1, 32'h0);
        checks++;
        if (a_busy !== 1'b1 || a_ready !== 1'b1 || a_sig !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL single_run: got busy=%b rdy=%b sig=%h want 1 1 ffffffff", a_busy, a_ready, a_sig);
        end
        feed(26'h0);
        checks++;
        if (a_done !== 1'b1 || a_sig !== 32'hFB3E_E249 || a_count !== 16'd1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%b sig=%h cnt=%0d rdy=%b want 1 fb3ee249 1 0",
                     a_done, a_sig, a_count, a_ready);
        end
    endtask

    task automatic test_zero();
        bit seen_ready;
        do_start(0, 32'hFFFF_FFFF);
        seen_ready = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_sig !== 32'hFFFF_FFFF || a_match !== 1'b1 || a_count !== 16'd0) begin
            errors++;
            $display("FAIL zero_a: got done=%b sig=%h match=%b cnt=%0d want 1 ffffffff 1 0",
                     a_done, a_sig, a_match, a_count);
        end
        checks++;
        if (b_done !== 1'b1 || b_sig !== 32'h0 || b_match !== 1'b0) begin
            errors++;
            $display("FAIL zero_b: got done=%b sig=%h match=%b want 1 00000000 0", b_done, b_sig, b_match);
        end
        resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (a_ready || b_ready) seen_ready = 1'b1;
            tick();
        end
        resp_valid = 1'b0;
        checks++;
        if (seen_ready || a_sig !== 32'hFFFF_FFFF || a_count !== 16'd0) begin
            errors++;
            $display("FAIL zero_noready: got ready_seen=%b sig=%h cnt=%0d want 0 ffffffff 0",
                     seen_ready, a_sig, a_count);
        end
    endtask

    task automatic test_golden();
        do_start(2, 32'h2);
        feed(26'h1);
        feed(26'h0);
        checks++;
        if (b_sig !== 32'h2 || b_match !== 1'b1 || b_done !== 1'b1) begin
            errors++;
            $display("FAIL golden_hit: got sig=%h match=%b done=%b want 00000002 1 1", b_sig, b_match, b_done);
        end
        checks++;
        if (a_sig !== ma || a_match !== (ma == 32'h2)) begin
            errors++;
            $display("FAIL golden_a: got sig=%h match=%b want %h %b", a_sig, a_match, ma, ma == 32'h2);
        end
        do_start(2, 32'h3);
        feed(26'h1);
        feed(26'h0);
        checks++;
        if (b_sig !== 32'h2 || b_match !== 1'b0 || b_done !== 1'b1) begin
            errors++;
            $display("FAIL golden_miss: got sig=%h match=%b done=%b want 00000002 0 1", b_sig, b_match, b_done);
        end
    endtask

    task automatic test_gaps();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int exp_cnt;
        do_start(3, 32'h0);
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (pat[i]) begin
                feed(26'h5);
                exp_cnt++;
            end else begin
                resp_data = 26'h3FF_FFFF;
                tick();
            end
            checks++;
            if (a_sig !== ma || b_sig !== mb || a_count !== 16'(exp_cnt) || a_done !== (exp_cnt == 3)) begin
                errors++;
                $display("FAIL gaps_step%0d: got sig=%h/%h cnt=%0d done=%b want %h/%h %0d %b",
                         i, a_sig, b_sig, a_count, a_done, ma, mb, exp_cnt, exp_cnt == 3);
            end
        end
        resp_valid = 1'b1;
        resp_data = 26'h5;
        tick();
        tick();
        resp_valid = 1'b0;
        checks++;
        if (a_count !== 16'd3 || a_sig !== ma || a_done !== 1'b1) begin
            errors++;
            $display("FAIL gaps_extra: got cnt=%0d sig=%h done=%b want 3 %h 1", a_count, a_sig, a_done, ma);
        end
    endtask

    task automatic test_reset_midrun();
        do_start(4, 32'h0);
        feed(26'h12345);
        feed(26'h2ABCDE);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_busy, a_done, a_match, a_sig, a_count} !== 52'h0) begin
            errors++;
            $display("FAIL midrun_reset: got rdy=%b busy=%b done=%b match=%b sig=%h cnt=%0d want all 0",
                     a_ready, a_busy, a_done, a_match, a_sig, a_count);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_idle: got busy=%b done=%b cnt=%0d want 0 0 0", a_busy, a_done, a_count);
        end
        test_single();
    endtask

    task automatic test_restart();
        logic [31:0] gold;
        gold = mstep(mstep(mstep(32'hFFFF_FFFF, 32'h11), 32'h22), 32'h33);
        do_start(3, gold);
        feed(26'h11);
        start = 1'b1;
        num_patterns = 16'd7;
        golden = 32'h0;
        feed(26'h22);
        start = 1'b0;
        feed(26'h33);
        checks++;
        if (a_done !== 1'b1 || a_count !== 16'd3 || a_sig !== gold || a_match !== 1'b1) begin
            errors++;
            $display("FAIL restart_ignore: got done=%b cnt=%0d sig=%h match=%b want 1 3 %h 1",
                     a_done, a_count, a_sig, a_match, gold);
        end
        do_start(2, mstep(mstep(32'hFFFF_FFFF, 32'h7), 32'h9));
        checks++;
        if (a_match !== 1'b0 || a_busy !== 1'b1 || a_count !== 16'd0 || a_sig !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL restart_clear: got match=%b busy=%b cnt=%0d sig=%h want 0 1 0 ffffffff",
                     a_match, a_busy, a_count, a_sig);
        end
        feed(26'h7);
        checks++;
        if (a_match !== 1'b0) begin
            errors++;
            $display("FAIL restart_midmatch: got match=%b want 0", a_match);
        end
        feed(26'h9);
        checks++;
        if (a_match !== 1'b1 || a_done !== 1'b1 || a_sig !== ma) begin
            errors++;
            $display("FAIL restart_done: got match=%b done=%b sig=%h want 1 1 %h", a_match, a_done, a_sig, ma);
        end
    endtask

    task automatic test_random();
        int n, acc, budget;
        bit use_model_gold;
        logic [25:0] d;
        logic [31:0] ga, gb;
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 12);
            use_model_gold = $urandom_range(0, 1) == 1;
            ga = $urandom;
            do_start(n, ga);
            acc = 0;
            budget = 200;
            while (acc < n && budget > 0) begin
                resp_valid = ($urandom_range(0, 1) == 1);
                d = 26'($urandom);
                resp_data = d;
                tick();
                if (resp_valid) begin
                    ma = mstep(ma, {6'b0, d});
                    mb = mstep(mb, {6'b0, d});
                    acc++;
                end
                budget--;
                checks++;
                if (a_count !== 16'(acc) || a_sig !== ma || b_sig !== mb) begin
                    errors++;
                    $display("FAIL rand%0d_step: got cnt=%0d sig=%h/%h want %0d %h/%h",
                             r, a_count, a_sig, b_sig, acc, ma, mb);
                end
            end
            resp_valid = 1'b0;
            checks++;
            if (a_done !== 1'b1 || b_done !== 1'b1 || a_match !== (ma == ga) || b_match !== (mb == ga)) begin
                errors++;
                $display("FAIL rand%0d_done: got done=%b/%b match=%b/%b want 1/1 %b/%b",
                         r, a_done, b_done, a_match, b_match, ma == ga, mb == ga);
            end
            if (use_model_gold) begin
                gb = ma;
                do_start(n, gb);
                for (int i = 0; i < n; i++) begin
                    feed(26'(r * 977 + i));
                end
                checks++;
                if (a_match !== (ma == gb) || a_sig !== ma) begin
                    errors++;
                    $display("FAIL rand%0d_gold: got match=%b sig=%h want %b %h", r, a_match, a_sig, ma == gb, ma);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_zero();
        test_golden();
        test_gaps();
        test_reset_midrun();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
